// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU and its nibble sequencer:
// op-codes, sequencer states, widths and the fix-up/carry decision helpers.
package alu_pkg;

    localparam int NIBBLE_W = 4;
    localparam int WORD_W   = 8;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        LO,
        HI,
        FIX,
        DONE
    } seq_state_t;

    // A third pass is needed when the low nibble spills into the high one
    // (carry/borrow) or a shift moves a bit across the nibble boundary.
    function automatic logic needs_fix(input logic [2:0] op, input logic carry_lo,
                                       input logic a_bit3, input logic a_bit4);
        case (op)
            OP_ADD, OP_SUB: return carry_lo;
            OP_SHL:         return a_bit3;
            OP_SHR:         return a_bit4;
            default:        return 1'b0;
        endcase
    endfunction

    function automatic logic word_carry(input logic [2:0] op, input logic arith_carry,
                                        input logic a_bit7, input logic a_bit0);
        case (op)
            OP_ADD, OP_SUB: return arith_carry;
            OP_SHL:         return a_bit7;
            OP_SHR:         return a_bit0;
            default:        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_nibble_sequencer_if.sv
// Command and response channels between a command source and the sequencer.
interface alu_nibble_sequencer_if;
    import alu_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [WORD_W-1:0] cmd_a;
    logic [WORD_W-1:0] cmd_b;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [WORD_W-1:0] rsp_result;
    logic              rsp_zero;
    logic              rsp_carry;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_carry
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_carry
    );

endinterface

// File: rtl/alu_nibble_sequencer.sv
// Runs 8-bit commands as low/high (and optional fix-up) nibble passes through
// one external 4-bit ALU, returning the word result with Zero/Carry flags.
module alu_nibble_sequencer
    import alu_pkg::*;
#(
    parameter int ALU_REG = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_nibble_sequencer_if.slave bus,
    output logic [NIBBLE_W-1:0] alu_a,
    output logic [NIBBLE_W-1:0] alu_b,
    output logic [2:0]          alu_op,
    input  logic [NIBBLE_W-1:0] alu_result,
    input  logic                alu_zero,
    input  logic                alu_carry,
    output logic                busy
);

    seq_state_t          state;
    logic                phase;
    logic [2:0]          op_q;
    logic [NIBBLE_W-1:0] a_hi_q;
    logic [NIBBLE_W-1:0] b_hi_q;
    logic                a_bit0_q;
    logic                a_bit3_q;
    logic [NIBBLE_W-1:0] lo_res;
    logic [NIBBLE_W-1:0] hi_res;
    logic                carry_lo;
    logic                carry_hi;

    logic                rsp_valid_q;
    logic [WORD_W-1:0]   rsp_result_q;
    logic                rsp_zero_q;
    logic                rsp_carry_q;

    logic                pass_last;
    logic [WORD_W-1:0]   done_word;
    logic                done_carry;
    logic                unused_alu_zero;

    assign unused_alu_zero = alu_zero;

    // A registered ALU needs a second cycle per pass before its result is valid.
    assign pass_last = (ALU_REG == 0) || phase;

    // Word assembled when leaving HI (no fix) or FIX; SHR fixes the low nibble.
    assign done_word  = (state == FIX && op_q == OP_SHR) ? {hi_res, alu_result}
                                                         : {alu_result, lo_res};
    assign done_carry = word_carry(op_q, (state == FIX) ? (carry_hi | alu_carry) : alu_carry,
                                   a_hi_q[3], a_bit0_q);

    assign bus.cmd_ready  = (state == IDLE);
    assign busy           = (state != IDLE);
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.rsp_carry  = rsp_carry_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            phase        <= 1'b0;
            op_q         <= OP_AND;
            a_hi_q       <= '0;
            b_hi_q       <= '0;
            a_bit0_q     <= 1'b0;
            a_bit3_q     <= 1'b0;
            lo_res       <= '0;
            hi_res       <= '0;
            carry_lo     <= 1'b0;
            carry_hi     <= 1'b0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op       <= OP_AND;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_carry_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        op_q     <= bus.cmd_op;
                        a_hi_q   <= bus.cmd_a[7:4];
                        b_hi_q   <= bus.cmd_b[7:4];
                        a_bit0_q <= bus.cmd_a[0];
                        a_bit3_q <= bus.cmd_a[3];
                        alu_a    <= bus.cmd_a[3:0];
                        alu_b    <= bus.cmd_b[3:0];
                        alu_op   <= bus.cmd_op;
                        phase    <= 1'b0;
                        state    <= LO;
                    end
                end
                LO: begin
                    if (!pass_last) begin
                        phase <= 1'b1;
                    end else begin
                        lo_res   <= alu_result;
                        carry_lo <= alu_carry;
                        alu_a    <= a_hi_q;
                        alu_b    <= b_hi_q;
                        phase    <= 1'b0;
                        state    <= HI;
                    end
                end
                HI: begin
                    if (!pass_last) begin
                        phase <= 1'b1;
                    end else begin
                        hi_res   <= alu_result;
                        carry_hi <= alu_carry;
                        phase    <= 1'b0;
                        if (needs_fix(op_q, carry_lo, a_bit3_q, a_hi_q[0])) begin
                            state <= FIX;
                            case (op_q)
                                OP_SHR: begin
                                    alu_a  <= lo_res;
                                    alu_b  <= 4'b1000;
                                    alu_op <= OP_OR;
                                end
                                OP_SHL: begin
                                    alu_a  <= alu_result;
                                    alu_b  <= 4'b0001;
                                    alu_op <= OP_OR;
                                end
                                default: begin
                                    alu_a  <= alu_result;
                                    alu_b  <= 4'b0001;
                                end
                            endcase
                        end else begin
                            rsp_result_q <= done_word;
                            rsp_zero_q   <= (done_word == '0);
                            rsp_carry_q  <= done_carry;
                            rsp_valid_q  <= 1'b1;
                            state        <= DONE;
                        end
                    end
                end
                FIX: begin
                    if (!pass_last) begin
                        phase <= 1'b1;
                    end else begin
                        rsp_result_q <= done_word;
                        rsp_zero_q   <= (done_word == '0);
                        rsp_carry_q  <= done_carry;
                        rsp_valid_q  <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Directed bench: two sequencers (combinational and registered ALU) each
// driving a behavioural 4-bit ALU, with hand-computed expected responses.
module tb_alu_nibble_sequencer;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_nibble_sequencer_if if0 ();
    alu_nibble_sequencer_if if1 ();

    logic [3:0] alu0_a, alu0_b, alu0_res;
    logic [2:0] alu0_op;
    logic       alu0_zero, alu0_carry, busy0;
    logic [3:0] alu1_a, alu1_b, alu1_res;
    logic [2:0] alu1_op;
    logic       alu1_zero, alu1_carry, busy1;

    function automatic logic [4:0] alu4(input logic [2:0] op, input logic [3:0] a,
                                        input logic [3:0] b);
        case (op)
            OP_AND:  return {1'b0, a & b};
            OP_OR:   return {1'b0, a | b};
            OP_XOR:  return {1'b0, a ^ b};
            OP_NOT:  return {1'b0, ~a};
            OP_ADD:  return {1'b0, a} + {1'b0, b};
            OP_SUB:  return {1'b0, a} - {1'b0, b};
            OP_SHL:  return {a[3], a[2:0], 1'b0};
            default: return {a[0], 1'b0, a[3:1]};
        endcase
    endfunction

    always_comb {alu0_carry, alu0_res} = alu4(alu0_op, alu0_a, alu0_b);
    assign alu0_zero = (alu0_res == 4'h0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) {alu1_carry, alu1_res} <= 5'h00;
        else        {alu1_carry, alu1_res} <= alu4(alu1_op, alu1_a, alu1_b);
    end
    assign alu1_zero = (alu1_res == 4'h0);

    alu_nibble_sequencer #(.ALU_REG(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0),
        .alu_a(alu0_a), .alu_b(alu0_b), .alu_op(alu0_op),
        .alu_result(alu0_res), .alu_zero(alu0_zero), .alu_carry(alu0_carry),
        .busy(busy0)
    );

    alu_nibble_sequencer #(.ALU_REG(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1),
        .alu_a(alu1_a), .alu_b(alu1_b), .alu_op(alu1_op),
        .alu_result(alu1_res), .alu_zero(alu1_zero), .alu_carry(alu1_carry),
        .busy(busy1)
    );

    task automatic check_output(input string tag, input logic [31:0] obs,
                                input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one command to dut0 and return the cycle (accept cycle = 0) at
    // which rsp_valid is first seen; leaves time #1 after that edge.
    task automatic apply_stimulus(input logic [2:0] op, input logic [7:0] a,
                                  input logic [7:0] b, output int lat);
        int n;
        @(negedge clk);
        if0.cmd_op    = op;
        if0.cmd_a     = a;
        if0.cmd_b     = b;
        if0.cmd_valid = 1'b1;
        n = 0;
        while (!if0.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        if0.cmd_valid = 1'b0;
        if0.cmd_op    = ~op;
        if0.cmd_a     = ~a;
        if0.cmd_b     = ~b;
        lat = 1;
        while (!if0.rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_cmd(input string tag, input logic [2:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] exp_res,
                           input logic exp_zero, input logic exp_carry, input int exp_lat);
        int lat;
        if0.rsp_ready = 1'b1;
        apply_stimulus(op, a, b, lat);
        check_output({tag, "_latency"}, lat, exp_lat);
        check_output({tag, "_result"}, if0.rsp_result, exp_res);
        check_output({tag, "_zero"}, if0.rsp_zero, exp_zero);
        check_output({tag, "_carry"}, if0.rsp_carry, exp_carry);
        @(posedge clk);
        #1;
        check_output({tag, "_ready_after"}, if0.cmd_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        if0.cmd_valid = 1'b0; if0.cmd_op = 3'b000; if0.cmd_a = 8'h00; if0.cmd_b = 8'h00;
        if0.rsp_ready = 1'b1;
        if1.cmd_valid = 1'b0; if1.cmd_op = 3'b000; if1.cmd_a = 8'h00; if1.cmd_b = 8'h00;
        if1.rsp_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check_output("rst_rsp_valid", if0.rsp_valid, 1'b0);
        check_output("rst_cmd_ready", if0.cmd_ready, 1'b1);
        check_output("rst_busy", busy0, 1'b0);
        check_output("rst_alu_a", alu0_a, 4'h0);
        check_output("rst_alu_op", alu0_op, 3'b000);
        check_output("rst_rsp_result", if0.rsp_result, 8'h00);
        check_output("rst_cmd_ready_reg", if1.cmd_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        run_cmd("add_3c_05", OP_ADD, 8'h3C, 8'h05, 8'h41, 1'b0, 1'b0, 4);
        run_cmd("add_ff_01", OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 4);
        run_cmd("sub_00_01", OP_SUB, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b1, 4);
        run_cmd("sub_10_01", OP_SUB, 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 4);
        run_cmd("shl_88",    OP_SHL, 8'h88, 8'h00, 8'h10, 1'b0, 1'b1, 4);
        run_cmd("shr_11",    OP_SHR, 8'h11, 8'h00, 8'h08, 1'b0, 1'b1, 4);
        run_cmd("xor_a5_ff", OP_XOR, 8'hA5, 8'hFF, 8'h5A, 1'b0, 1'b0, 3);
        run_cmd("not_0f",    OP_NOT, 8'h0F, 8'h00, 8'hF0, 1'b0, 1'b0, 3);
        run_cmd("add_12_34", OP_ADD, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 3);

        // Backpressure: response held for 5 cycles with the next command waiting.
        if0.rsp_ready = 1'b0;
        apply_stimulus(OP_ADD, 8'h3C, 8'h05, lat);
        check_output("bp_latency", lat, 4);
        check_output("bp_result", if0.rsp_result, 8'h41);
        if0.cmd_op    = OP_OR;
        if0.cmd_a     = 8'h0F;
        if0.cmd_b     = 8'h30;
        if0.cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_output($sformatf("bp_hold_valid_%0d", i), if0.rsp_valid, 1'b1);
            check_output($sformatf("bp_hold_result_%0d", i), if0.rsp_result, 8'h41);
            check_output($sformatf("bp_hold_ready_%0d", i), if0.cmd_ready, 1'b0);
        end
        @(negedge clk);
        if0.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check_output("bp_release_valid", if0.rsp_valid, 1'b0);
        check_output("bp_release_ready", if0.cmd_ready, 1'b1);
        @(posedge clk);
        #1;
        check_output("bp_next_accepted", busy0, 1'b1);
        if0.cmd_valid = 1'b0;
        lat = 1;
        while (!if0.rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_output("bp_next_latency", lat, 3);
        check_output("bp_next_result", if0.rsp_result, 8'h3F);
        @(posedge clk);
        #1;

        // Reset during the HI pass of an ADD aborts without a response.
        @(negedge clk);
        if0.cmd_op = OP_ADD; if0.cmd_a = 8'h3C; if0.cmd_b = 8'h05; if0.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        if0.cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        check_output("midrst_busy_before", busy0, 1'b1);
        rst_n = 1'b0;
        #1;
        check_output("midrst_busy", busy0, 1'b0);
        check_output("midrst_cmd_ready", if0.cmd_ready, 1'b1);
        check_output("midrst_rsp_valid", if0.rsp_valid, 1'b0);
        check_output("midrst_alu_a", alu0_a, 4'h0);
        check_output("midrst_alu_b", alu0_b, 4'h0);
        check_output("midrst_alu_op", alu0_op, 3'b000);
        check_output("midrst_rsp_result", if0.rsp_result, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check_output($sformatf("midrst_no_rsp_%0d", i), if0.rsp_valid, 1'b0);
        end
        run_cmd("and_f0_3c", OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 3);

        // Registered ALU: every pass takes two cycles.
        @(negedge clk);
        if1.cmd_op = OP_ADD; if1.cmd_a = 8'h3C; if1.cmd_b = 8'h05; if1.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        if1.cmd_valid = 1'b0;
        if1.cmd_a     = 8'h00;
        lat = 1;
        while (!if1.rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_output("reg_latency", lat, 7);
        check_output("reg_result", if1.rsp_result, 8'h41);
        check_output("reg_zero", if1.rsp_zero, 1'b0);
        check_output("reg_carry", if1.rsp_carry, 1'b0);
        @(posedge clk);
        #1;
        check_output("reg_ready_after", if1.cmd_ready, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
